drp_reconf_seq: RTL
===================

DRP_RECONF_SEQ -- requirements
Module: drp_reconf_seq

Interface
REQ-001 Parameter N_ENTRIES, default 4: number of register-table entries per reconfiguration run, range 1..32.
REQ-002 Parameter TIMEOUT_CYCLES, default 1024: wait limit in DCLK cycles; used only with DRP_TIMEOUT_EN.
REQ-003 Port DCLK, input, 1 bit: single clock; all logic rises on it; drives the PLL DRP clock.
REQ-004 Port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port START, input, 1 bit: level sampled in IDLE; starts one run.
REQ-006 Port BUSY, output, 1 bit: high in every state except IDLE.
REQ-007 Port DONE, output, 1 bit: one-cycle pulse when a run completes successfully.
REQ-008 Port ERROR, output, 1 bit: sticky timeout flag.
REQ-009 Port TBL_IDX, output, 5 bits: current table index.
REQ-010 Ports TBL_ADDR (input, 7 bits), TBL_MASK (input, 16 bits), TBL_DATA (input, 16 bits): combinational table entry selected by TBL_IDX.
REQ-011 Ports DADDR (output, 7 bits), DEN (output, 1 bit), DWE (output, 1 bit), DI (output, 16 bits), DO (input, 16 bits), DRDY (input, 1 bit): DRP master side.
REQ-012 Port PLL_RST, output, 1 bit: PLL reset, active-high. Port LOCKED, input, 1 bit: PLL lock status.

Function
REQ-013 The FSM SHALL use these states: IDLE, HOLD, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, NEXT, RELEASE, LOCK_WAIT, ERR.
REQ-014 In IDLE with START=1, the block SHALL clear ERROR and TBL_IDX and enter HOLD. START in any other state SHALL be ignored.
REQ-015 HOLD SHALL assert PLL_RST for 1 cycle, then enter RD_REQ. PLL_RST SHALL stay high from HOLD through RELEASE.
REQ-016 RD_REQ SHALL drive DEN=1, DWE=0, DADDR=TBL_ADDR for exactly 1 cycle, then enter RD_WAIT.
REQ-017 In RD_WAIT, on DRDY=1 the block SHALL latch DO into rdata and enter WR_REQ.
REQ-018 WR_REQ SHALL drive DEN=1, DWE=1, DADDR=TBL_ADDR, DI=(rdata & TBL_MASK) | (TBL_DATA & ~TBL_MASK) for exactly 1 cycle. Mask bit 1 keeps the old bit.
REQ-019 In WR_WAIT, on DRDY=1 the block SHALL enter NEXT.
REQ-020 NEXT SHALL increment TBL_IDX. If the incremented value equals N_ENTRIES, go to RELEASE, otherwise go to RD_REQ. TBL_IDX SHALL never exceed N_ENTRIES-1 while a DRP request is outstanding.
REQ-021 RELEASE SHALL deassert PLL_RST and enter LOCK_WAIT.
REQ-022 In LOCK_WAIT, on LOCKED=1 the block SHALL pulse DONE for 1 cycle and return to IDLE.
REQ-023 DEN SHALL be high for at most 1 cycle per transaction. Only one transaction SHALL be outstanding at a time.
REQ-024 DRDY in any state other than RD_WAIT or WR_WAIT SHALL be ignored.
REQ-025 DADDR, DI and DWE SHALL be 0 whenever DEN=0.
REQ-026 Minimum run latency SHALL be 1 + N_ENTRIES*(DRP round trips + 3) + 2 cycles, measured START to DONE, with DRDY returning one cycle after DEN and LOCKED already high.

Reset
REQ-027 On RST_N=0, asynchronously: state=IDLE, BUSY=0, DONE=0, ERROR=0, TBL_IDX=0, DEN=0, DWE=0, DADDR=0, DI=0, rdata=0, PLL_RST=0.
REQ-028 Reset asserted mid-run SHALL abort the run with no further DRP access. A DRDY arriving after reset release SHALL be ignored.

Configuration
REQ-029 With macro DRP_TIMEOUT_EN defined: a counter SHALL run in RD_WAIT, WR_WAIT and LOCK_WAIT.
- Reaching TIMEOUT_CYCLES -> enter ERR.
- ERR: PLL_RST=0, ERROR=1, DONE not pulsed; the block then returns to IDLE with ERROR held until the next START.
- The counter SHALL clear on every state change.
REQ-030 Without DRP_TIMEOUT_EN: no counter, ERR unreachable, ERROR tied to 0, waits are unbounded.

Structure
REQ-031 A shared package drp_pkg SHALL hold the state encoding, the DRP address width (7) and data width (16), and the mask-merge function.
REQ-032 One sub-module, drp_xfer, SHALL hold the single-transaction engine: a one-cycle DEN request, DRDY wait, read-data latch and optional timeout. The FSM instantiates it once.
REQ-033 The table storage SHALL be external to this block.

Verification
REQ-034 Reset: RST_N=0 mid-RD_WAIT -> all outputs at reset values within the same cycle; a later DRDY=1 leaves state IDLE.
REQ-035 Single entry: N_ENTRIES=1, entry (0x08, mask 0xF000, data 0x0123), DO=0x9999 -> one read of 0x08, then a write of 0x9123 to 0x08, then DONE once LOCKED=1.
REQ-036 Four entries (0x08, 0x09, 0x14, 0x15), mask 0x0000 -> exactly 4 read/write pairs in index order. PLL_RST stays high throughout and falls before LOCK_WAIT.
REQ-037 START held high during a run, plus a spurious DRDY in IDLE -> no second run and no extra DEN pulse.
REQ-038 With DRP_TIMEOUT_EN, TIMEOUT_CYCLES=16, DRDY never returned -> ERROR=1 after 16 RD_WAIT cycles, PLL_RST=0, no DONE. A following START clears ERROR.

Source files
------------

// File: rtl/drp_pkg.sv
// Shared DRP sequencer types: state encoding, DRP bus widths and the mask-merge helper.
// DRP_TIMEOUT_EN (when defined) turns on the wait-state watchdog and the ERR path.
package drp_pkg;

  localparam int DRP_AW = 7;
  localparam int DRP_DW = 16;

  typedef enum logic [3:0] {
    IDLE,
    HOLD,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    NEXT,
    RELEASE,
    LOCK_WAIT,
    ERR
  } state_t;

  typedef enum logic [1:0] {
    X_IDLE,
    X_REQ,
    X_WAIT
  } xfer_phase_t;

`ifdef DRP_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  // A set mask bit keeps the bit read back from the PLL.
  function automatic logic [DRP_DW-1:0] mask_merge(input logic [DRP_DW-1:0] old_val,
                                                   input logic [DRP_DW-1:0] mask,
                                                   input logic [DRP_DW-1:0] new_val);
    return (old_val & mask) | (new_val & ~mask);
  endfunction

endpackage

// File: rtl/drp_xfer.sv
// Single DRP transaction engine: one-cycle DEN request, DRDY wait, read-data latch.
// Optional watchdog (DRP_TIMEOUT_EN) also covers the sequencer's lock wait.
module drp_xfer
  import drp_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              we,
  input  logic [DRP_AW-1:0] addr,
  input  logic [DRP_DW-1:0] wdata,
  input  logic [DRP_DW-1:0] dout,
  input  logic              drdy,
  input  logic              lock_pending,
  output logic              den,
  output logic              dwe,
  output logic [DRP_AW-1:0] daddr,
  output logic [DRP_DW-1:0] di,
  output logic              ack,
  output logic              timeout,
  output logic [DRP_DW-1:0] rdata
);

  xfer_phase_t phase;
  logic        we_q;

  // A new request may be launched in the same cycle the previous one is acknowledged,
  // so the write can follow the read without a gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= X_IDLE;
      we_q  <= 1'b0;
      rdata <= '0;
    end else begin
      if (ack && !we_q) begin
        rdata <= dout;
      end
      if (go) begin
        phase <= X_REQ;
        we_q  <= we;
      end else begin
        case (phase)
          X_REQ:   phase <= X_WAIT;
          X_WAIT:  if (ack || timeout) phase <= X_IDLE;
          default: phase <= X_IDLE;
        endcase
      end
    end
  end

  // Address and data are gated views of the current table entry so the bus idles at zero.
  assign den   = (phase == X_REQ);
  assign dwe   = den && we_q;
  assign daddr = den ? addr : '0;
  assign di    = dwe ? wdata : '0;
  assign ack   = (phase == X_WAIT) && drdy;

`ifdef DRP_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          counting;

  assign counting = (phase == X_WAIT) || lock_pending;
  assign timeout  = counting && !ack && (cnt == CW'(TIMEOUT_CYCLES - 1));

  // Any exit from a wait state drops 'counting', which clears the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (counting && !ack && !timeout) begin
      cnt <= cnt + CW'(1);
    end else begin
      cnt <= '0;
    end
  end
`else
  logic        unused_lock_pending;
  logic [31:0] unused_timeout_cycles;

  assign unused_lock_pending   = lock_pending;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout               = 1'b0;
`endif

endmodule

// File: rtl/drp_reconf_seq.sv
// PLL DRP reconfiguration sequencer: holds the PLL in reset, read-modify-writes N_ENTRIES table
// entries, then waits for lock. Watchdog and ERR path exist only with DRP_TIMEOUT_EN.
module drp_reconf_seq
  import drp_pkg::*;
#(
  parameter int N_ENTRIES      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              DCLK,
  input  logic              RST_N,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERROR,
  output logic [4:0]        TBL_IDX,
  input  logic [DRP_AW-1:0] TBL_ADDR,
  input  logic [DRP_DW-1:0] TBL_MASK,
  input  logic [DRP_DW-1:0] TBL_DATA,
  output logic [DRP_AW-1:0] DADDR,
  output logic              DEN,
  output logic              DWE,
  output logic [DRP_DW-1:0] DI,
  input  logic [DRP_DW-1:0] DO,
  input  logic              DRDY,
  output logic              PLL_RST,
  input  logic              LOCKED
);

  localparam logic [4:0] LAST_IDX = 5'(N_ENTRIES - 1);

  state_t            state;
  logic              error_q;
  logic              go_rd;
  logic              go_wr;
  logic              lock_pending;
  logic              xfer_ack;
  logic              xfer_timeout;
  logic [DRP_DW-1:0] rdata;

  assign go_rd        = (state == HOLD) || ((state == NEXT) && (TBL_IDX != LAST_IDX));
  assign go_wr        = (state == RD_WAIT) && xfer_ack;
  assign lock_pending = (state == LOCK_WAIT) && !LOCKED;
  assign ERROR        = TIMEOUT_EN && error_q;

  drp_xfer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_xfer (
    .clk         (DCLK),
    .rst_n       (RST_N),
    .go          (go_rd || go_wr),
    .we          (go_wr),
    .addr        (TBL_ADDR),
    .wdata       (mask_merge(rdata, TBL_MASK, TBL_DATA)),
    .dout        (DO),
    .drdy        (DRDY),
    .lock_pending(lock_pending),
    .den         (DEN),
    .dwe         (DWE),
    .daddr       (DADDR),
    .di          (DI),
    .ack         (xfer_ack),
    .timeout     (xfer_timeout),
    .rdata       (rdata)
  );

  always_ff @(posedge DCLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      error_q <= 1'b0;
      TBL_IDX <= '0;
      PLL_RST <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            error_q <= 1'b0;
            TBL_IDX <= '0;
            BUSY    <= 1'b1;
            PLL_RST <= 1'b1;
            state   <= HOLD;
          end
        end
        HOLD:    state <= RD_REQ;
        RD_REQ:  state <= RD_WAIT;
        RD_WAIT: begin
          if (xfer_ack) begin
            state <= WR_REQ;
          end else if (xfer_timeout) begin
            PLL_RST <= 1'b0;
            error_q <= 1'b1;
            state   <= ERR;
          end
        end
        WR_REQ:  state <= WR_WAIT;
        WR_WAIT: begin
          if (xfer_ack) begin
            state <= NEXT;
          end else if (xfer_timeout) begin
            PLL_RST <= 1'b0;
            error_q <= 1'b1;
            state   <= ERR;
          end
        end
        // The index stays on the last entry rather than wrapping, so it fits 5 bits at 32 entries.
        NEXT: begin
          if (TBL_IDX == LAST_IDX) begin
            state <= RELEASE;
          end else begin
            TBL_IDX <= TBL_IDX + 5'd1;
            state   <= RD_REQ;
          end
        end
        RELEASE: begin
          PLL_RST <= 1'b0;
          state   <= LOCK_WAIT;
        end
        LOCK_WAIT: begin
          if (LOCKED) begin
            DONE  <= 1'b1;
            BUSY  <= 1'b0;
            state <= IDLE;
          end else if (xfer_timeout) begin
            error_q <= 1'b1;
            state   <= ERR;
          end
        end
        ERR: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          BUSY    <= 1'b0;
          PLL_RST <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
